// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared access-size codes, FSM states and lane helpers for dmem_responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Byte lanes touched by an access of size f3 at byte offset off within the word.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Misaligned halves/words, reserved size codes and unsigned stores are rejected.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off,
                                          input logic is_store);
        logic flt;
        case (f3)
            F3_B:    flt = 1'b0;
            F3_BU:   flt = is_store;
            F3_H:    flt = off[0];
            F3_HU:   flt = off[0] | is_store;
            F3_W:    flt = (off != 2'b00);
            default: flt = 1'b1;
        endcase
        return flt;
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// rtl/dmem_sram_bank.sv - single-port word RAM with byte write enables and registered read
module dmem_sram_bank #(
    parameter int dw    = 32,
    parameter int depth = 1024,
    parameter int aw    = $clog2(depth)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [aw-1:0] addr_i,
    input  logic [dw-1:0] wdata_i,
    output logic [dw-1:0] rdata_o
);

    logic [dw-1:0] mem_q [depth];
    logic [dw-1:0] rdata_q;

    // Contents are deliberately not reset; a write cycle leaves the read register untouched.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (|we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (we_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I load/store responder: handshake, wait states, faults, lane extract
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int width = 32,
    parameter int depth = 1024,
    parameter int WAIT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] addr,
    input  logic [width-1:0] wdata,
    output logic             ready,
    output logic [width-1:0] rdata,
    output logic             fault,
    output logic             busy
);

    localparam int AW = $clog2(depth);
    localparam logic [2:0] WAIT_LD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    state_e           state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [AW+1:0]    addr_q, addr_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic             ready_q, ready_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic             fault_q, fault_d;

    logic             ram_en;
    logic [3:0]       ram_we;
    logic [AW-1:0]    ram_addr;
    logic [width-1:0] ram_wdata;
    logic [width-1:0] ram_rdata;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [width-1:0] ld_ext;

    dmem_sram_bank #(
        .dw    (width),
        .depth (depth),
        .aw    (AW)
    ) u_bank (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Narrow store data is replicated so every selected lane sees the right bytes.
    always_comb begin
        case (f3_q)
            F3_B:    ram_wdata = {4{wdata_q[7:0]}};
            F3_H:    ram_wdata = {2{wdata_q[15:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

    assign ld_byte = ram_rdata[8*addr_q[1:0] +: 8];
    assign ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (f3_q)
            F3_B:    ld_ext = {{(width-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {{(width-8){1'b0}}, ld_byte};
            F3_H:    ld_ext = {{(width-16){ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {{(width-16){1'b0}}, ld_half};
            default: ld_ext = ram_rdata;
        endcase
    end

    // Load reads are launched on the edge entering ACCESS so the data is ready to
    // register into rdata on the ACCESS edge; stores write on the ACCESS edge itself.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        ram_en   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = addr_q[AW+1:2];

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (access_fault(funct3, addr[1:0], we)) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LD;
                    end else begin
                        state_d  = ST_ACCESS;
                        ram_en   = ~we;
                        ram_addr = addr[AW+1:2];
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    state_d = ST_ACCESS;
                    ram_en  = ~we_q;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                ready_d = 1'b1;
                fault_d = 1'b0;
                if (we_q) begin
                    ram_en  = 1'b1;
                    ram_we  = lane_be(f3_q, addr_q[1:0]);
                    rdata_d = '0;
                end else begin
                    rdata_d = ld_ext;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign fault = fault_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a byte-array model
module tb_dmem_responder;

    localparam int WAIT_P  = 1;
    localparam int DEPTH_P = 1024;
    localparam int NBYTES  = 4 * DEPTH_P;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        fault;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_m   [NBYTES];
    bit         known_m [NBYTES];

    dmem_responder #(
        .width (32),
        .depth (DEPTH_P),
        .WAIT  (WAIT_P)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .fault  (fault),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte memory, address taken modulo the RAM size.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic exp_flt, output int exp_lat,
                         output logic [31:0] exp_rd, output bit rd_known);
        int n;
        int base;
        logic [31:0] v;
        exp_flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
               || ((f3 == 3'd1 || f3 == 3'd5) && a[0])
               || (f3 == 3'd2 && a[1:0] != 2'b00)
               || ((f3 == 3'd4 || f3 == 3'd5) && w);
        exp_lat  = exp_flt ? 1 : 2 + WAIT_P;
        exp_rd   = '0;
        rd_known = !exp_flt;
        if (!exp_flt) begin
            n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            base = int'(a % NBYTES);
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    mem_m[base + i]   = d[8*i +: 8];
                    known_m[base + i] = 1'b1;
                end
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) begin
                    v = v | (32'(mem_m[base + i]) << (8 * i));
                    if (!known_m[base + i]) rd_known = 1'b0;
                end
                if (!f3[2] && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                exp_rd = v;
            end
        end
    endtask

    task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic flt);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
        lat = 1;
        check("busy", 32'(busy), 32'd1);
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            check("busy", 32'(busy), 32'd1);
        end
        rd  = rdata;
        flt = fault;
        @(posedge clk); #1;
        check("ready_pulse", 32'(ready), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int lat, elat;
        logic flt, eflt;
        logic [31:0] erd;
        bit rk;
        xact(w, f3, a, d, lat, rd, flt);
        model(w, f3, a, d, eflt, elat, erd, rk);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_fault"}, 32'(flt), 32'(eflt));
        if (rk) check({tag, "_rdata"}, rd, erd);
    endtask

    initial begin
        logic [31:0] rd;
        int pulses;
        for (int i = 0; i < NBYTES; i++) known_m[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
        check("sw10_zero", rd, 32'd0);
        run("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("lw10_val", rd, 32'hDEADBEEF);

        run("sw10b", 1'b1, 3'd2, 32'h10, 32'h11223344, rd);
        run("sb13", 1'b1, 3'd0, 32'h13, 32'h00000080, rd);
        run("lb13", 1'b0, 3'd0, 32'h13, 32'h0, rd);
        check("lb13_val", rd, 32'hFFFFFF80);
        run("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, rd);
        check("lbu13_val", rd, 32'h00000080);
        run("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("lw10c_val", rd, 32'h80223344);

        run("sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, rd);
        run("sh22", 1'b1, 3'd1, 32'h22, 32'h0000A5A5, rd);
        run("lh22", 1'b0, 3'd1, 32'h22, 32'h0, rd);
        check("lh22_val", rd, 32'hFFFFA5A5);
        run("lhu22", 1'b0, 3'd5, 32'h22, 32'h0, rd);
        check("lhu22_val", rd, 32'h0000A5A5);
        run("lhu20", 1'b0, 3'd5, 32'h20, 32'h0, rd);
        check("lhu20_val", rd, 32'h00003344);

        run("f_lw02", 1'b0, 3'd2, 32'h02, 32'h0, rd);
        run("f_sh11", 1'b1, 3'd1, 32'h11, 32'h0000BEEF, rd);
        run("f_sw12", 1'b1, 3'd2, 32'h12, 32'hCAFECAFE, rd);
        run("f_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, rd);
        run("f_sbu", 1'b1, 3'd4, 32'h10, 32'h000000EE, rd);
        run("f_readback", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        check("f_readback_val", rd, 32'h80223344);

        run("sw1000", 1'b1, 3'd2, 32'h1000, 32'h12345678, rd);
        run("lw0", 1'b0, 3'd2, 32'h0, 32'h0, rd);
        check("wrap_val", rd, 32'h12345678);

        run("sw40", 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, rd);
        run("lw0b", 1'b0, 3'd2, 32'h0, 32'h0, rd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        check("rstw_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("rstw_ready", 32'(ready), 32'd0);
        check("rstw_rdata", rdata, 32'd0);
        check("rstw_fault", 32'(fault), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run("lw40", 1'b0, 3'd2, 32'h40, 32'h0, rd);
        check("lw40_val", rd, 32'hCAFEF00D);

        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10;
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                check("held_pos", 32'(k), 32'(3 + (3 + WAIT_P) * pulses));
                check("held_rdata", rdata, 32'h80223344);
                pulses++;
            end
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check("held_pulses", 32'(pulses), 32'd4);
        check("held_idle", 32'(busy), 32'd0);

        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h20;
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            addr = 32'h40; we = 1'b1;
            if (ready) begin
                pulses++;
                check("ign_pos", 32'(k), 32'(2 + WAIT_P));
                check("ign_rdata", rdata, 32'hA5A53344);
            end
        end
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("ign_pulses", 32'(pulses), 32'd1);

        for (int i = 0; i < 16; i++) run("init", 1'b1, 3'd2, 32'(i * 4), $urandom, rd);
        for (int i = 0; i < 160; i++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            run("rnd", w, f3, a, $urandom, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
